// File: rtl/cascade_pkg.sv
// Shared types and geometry helpers for the window scanner.
// Holds the FSM state encoding and the window-count function.
package cascade_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT_RES,
    EMIT,
    DONE
  } scan_state_t;

  function automatic int num_pos(
    input int img,
    input int win,
    input int step
  );
    return (img - win) / step + 1;
  endfunction

endpackage

// File: rtl/win_addr_gen.sv
// Pixel address generator for one window position.
// Walks px/py row-major and keeps row_base incrementally.
module win_addr_gen
  import cascade_pkg::*;
#(
  parameter int IMG_WIDTH  = 45,
  parameter int IMG_HEIGHT = 45,
  parameter int WIN_WIDTH  = 24,
  parameter int WIN_HEIGHT = 24,
  parameter int STEP       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_window,
  input  logic [$clog2(IMG_WIDTH)-1:0] win_x,
  input  logic [$clog2(IMG_HEIGHT)-1:0] win_y,
  input  logic step_ok,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] addr_data,
  output logic last_pixel
);

  localparam int W_ADDR = $clog2(IMG_WIDTH*IMG_HEIGHT);
  localparam int W_X = $clog2(IMG_WIDTH);
  localparam int W_Y = $clog2(IMG_HEIGHT);

  localparam logic [W_X-1:0] PX_LAST = W_X'(WIN_WIDTH-1);
  localparam logic [W_Y-1:0] PY_LAST = W_Y'(WIN_HEIGHT-1);
  localparam logic [W_ADDR-1:0] ROW_INC = W_ADDR'(IMG_WIDTH);
  localparam logic [W_ADDR-1:0] Y_INC = W_ADDR'(STEP*IMG_WIDTH);

  logic [W_X-1:0] px;
  logic [W_X-1:0] x_base;
  logic [W_Y-1:0] py;
  logic [W_Y-1:0] y_cur;
  logic [W_ADDR-1:0] row_base;
  logic [W_ADDR-1:0] y_base;
  logic [W_ADDR-1:0] y_base_nx;

  // win_y only ever restarts at 0 or grows by STEP
  always_comb begin
    y_base_nx = y_base;
    if (win_y == '0)
      y_base_nx = '0;
    else if (win_y != y_cur)
      y_base_nx = y_base + Y_INC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px       <= '0;
      py       <= '0;
      x_base   <= '0;
      y_cur    <= '0;
      y_base   <= '0;
      row_base <= '0;
    end else if (load_window) begin
      px       <= '0;
      py       <= '0;
      x_base   <= win_x;
      y_cur    <= win_y;
      y_base   <= y_base_nx;
      row_base <= y_base_nx;
    end else if (step_ok) begin
      if (px == PX_LAST) begin
        px       <= '0;
        py       <= py + 1'b1;
        row_base <= row_base + ROW_INC;
      end else begin
        px <= px + 1'b1;
      end
    end
  end

  assign addr_data = row_base
                   + W_ADDR'(x_base)
                   + W_ADDR'(px);

  assign last_pixel = (px == PX_LAST)
                   && (py == PY_LAST);

endmodule

// File: rtl/window_scanner.sv
// Read-side sequencer: walks a window over the image and
// emits one tagged detection record per window position.
module window_scanner
  import cascade_pkg::*;
#(
  parameter int IMG_WIDTH  = 45,
  parameter int IMG_HEIGHT = 45,
  parameter int WIN_WIDTH  = 24,
  parameter int WIN_HEIGHT = 24,
  parameter int STEP       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start_valid,
  output logic start_ready,
  output logic addr_valid,
  input  logic addr_ready,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] addr_data,
  input  logic res_valid,
  output logic res_ready,
  input  logic res_hit,
  output logic det_valid,
  input  logic det_ready,
  output logic [$clog2(IMG_WIDTH)-1:0] det_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] det_y,
  output logic det_hit,
  output logic frame_done,
  output logic busy
);

  localparam int W_X = $clog2(IMG_WIDTH);
  localparam int W_Y = $clog2(IMG_HEIGHT);
  localparam int NX = num_pos(IMG_WIDTH, WIN_WIDTH, STEP);
  localparam int NY = num_pos(IMG_HEIGHT, WIN_HEIGHT, STEP);

  localparam logic [W_X-1:0] X_LAST = W_X'((NX-1)*STEP);
  localparam logic [W_Y-1:0] Y_LAST = W_Y'((NY-1)*STEP);
  localparam logic [W_X-1:0] X_STEP = W_X'(STEP);
  localparam logic [W_Y-1:0] Y_STEP = W_Y'(STEP);

  scan_state_t state;
  scan_state_t state_nx;

  logic [W_X-1:0] win_x;
  logic [W_X-1:0] nx_x;
  logic [W_Y-1:0] win_y;
  logic [W_Y-1:0] nx_y;
  logic load_window;
  logic step_ok;
  logic last_pixel;

  assign step_ok = addr_valid && addr_ready;

  always_comb begin
    state_nx    = state;
    load_window = 1'b0;
    nx_x        = win_x;
    nx_y        = win_y;
    unique case (state)
      IDLE: begin
        if (start_valid) begin
          state_nx    = ADDR;
          load_window = 1'b1;
          nx_x        = '0;
          nx_y        = '0;
        end
      end
      ADDR: begin
        if (step_ok && last_pixel)
          state_nx = WAIT_RES;
      end
      WAIT_RES: begin
        if (res_valid)
          state_nx = EMIT;
      end
      EMIT: begin
        if (det_ready) begin
          if (win_x != X_LAST) begin
            state_nx    = ADDR;
            load_window = 1'b1;
            nx_x        = win_x + X_STEP;
          end else if (win_y != Y_LAST) begin
            state_nx    = ADDR;
            load_window = 1'b1;
            nx_x        = '0;
            nx_y        = win_y + Y_STEP;
          end else begin
            state_nx = DONE;
          end
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      win_x   <= '0;
      win_y   <= '0;
      det_x   <= '0;
      det_y   <= '0;
      det_hit <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_window) begin
        win_x <= nx_x;
        win_y <= nx_y;
      end
      if (state == WAIT_RES && res_valid) begin
        det_hit <= res_hit;
        det_x   <= win_x;
        det_y   <= win_y;
      end
    end
  end

  win_addr_gen #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .WIN_WIDTH  (WIN_WIDTH),
    .WIN_HEIGHT (WIN_HEIGHT),
    .STEP       (STEP)
  ) u_gen (
    .clk         (clk),
    .rst         (rst),
    .load_window (load_window),
    .win_x       (nx_x),
    .win_y       (nx_y),
    .step_ok     (step_ok),
    .addr_data   (addr_data),
    .last_pixel  (last_pixel)
  );

  assign start_ready = (state == IDLE);
  assign addr_valid  = (state == ADDR);
  assign res_ready   = (state == WAIT_RES);
  assign det_valid   = (state == EMIT);
  assign frame_done  = (state == DONE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_window_scanner.sv
// Directed bench for window_scanner over several geometries.
// One stimulus path is muxed onto the selected instance.
module tb_window_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_valid, addr_ready;
  logic res_valid, res_hit, det_ready;
  int   sel;

  logic a_sr, a_av, a_rr, a_dv, a_dh, a_fd, a_bz;
  logic [3:0] a_ad;
  logic [1:0] a_dx, a_dy;
  logic b_sr, b_av, b_rr, b_dv, b_dh, b_fd, b_bz;
  logic [10:0] b_ad;
  logic [5:0] b_dx, b_dy;
  logic c_sr, c_av, c_rr, c_dv, c_dh, c_fd, c_bz;
  logic [3:0] c_ad;
  logic [1:0] c_dx, c_dy;
  logic d_sr, d_av, d_rr, d_dv, d_dh, d_fd, d_bz;
  logic [10:0] d_ad;
  logic [5:0] d_dx, d_dy;

  logic m_sr, m_av, m_rr, m_dv, m_dh, m_fd, m_bz;
  int   m_ad, m_dx, m_dy;

  window_scanner #(4, 4, 2, 2, 2) u_a (
    .clk(clk), .rst(rst),
    .start_valid(start_valid && sel == 0),
    .start_ready(a_sr), .addr_valid(a_av),
    .addr_ready(addr_ready), .addr_data(a_ad),
    .res_valid(res_valid), .res_ready(a_rr),
    .res_hit(res_hit), .det_valid(a_dv),
    .det_ready(det_ready), .det_x(a_dx),
    .det_y(a_dy), .det_hit(a_dh),
    .frame_done(a_fd), .busy(a_bz));

  window_scanner u_b (
    .clk(clk), .rst(rst),
    .start_valid(start_valid && sel == 1),
    .start_ready(b_sr), .addr_valid(b_av),
    .addr_ready(addr_ready), .addr_data(b_ad),
    .res_valid(res_valid), .res_ready(b_rr),
    .res_hit(res_hit), .det_valid(b_dv),
    .det_ready(det_ready), .det_x(b_dx),
    .det_y(b_dy), .det_hit(b_dh),
    .frame_done(b_fd), .busy(b_bz));

  window_scanner #(3, 3, 3, 3, 1) u_c (
    .clk(clk), .rst(rst),
    .start_valid(start_valid && sel == 2),
    .start_ready(c_sr), .addr_valid(c_av),
    .addr_ready(addr_ready), .addr_data(c_ad),
    .res_valid(res_valid), .res_ready(c_rr),
    .res_hit(res_hit), .det_valid(c_dv),
    .det_ready(det_ready), .det_x(c_dx),
    .det_y(c_dy), .det_hit(c_dh),
    .frame_done(c_fd), .busy(c_bz));

  window_scanner #(45, 45, 24, 24, 8) u_d (
    .clk(clk), .rst(rst),
    .start_valid(start_valid && sel == 3),
    .start_ready(d_sr), .addr_valid(d_av),
    .addr_ready(addr_ready), .addr_data(d_ad),
    .res_valid(res_valid), .res_ready(d_rr),
    .res_hit(res_hit), .det_valid(d_dv),
    .det_ready(det_ready), .det_x(d_dx),
    .det_y(d_dy), .det_hit(d_dh),
    .frame_done(d_fd), .busy(d_bz));

  always_comb begin
    {m_sr, m_av, m_rr, m_dv} = {a_sr, a_av, a_rr, a_dv};
    {m_dh, m_fd, m_bz} = {a_dh, a_fd, a_bz};
    m_ad = int'(a_ad);
    m_dx = int'(a_dx);
    m_dy = int'(a_dy);
    case (sel)
      1: begin
        {m_sr, m_av, m_rr, m_dv} = {b_sr, b_av, b_rr, b_dv};
        {m_dh, m_fd, m_bz} = {b_dh, b_fd, b_bz};
        m_ad = int'(b_ad);
        m_dx = int'(b_dx);
        m_dy = int'(b_dy);
      end
      2: begin
        {m_sr, m_av, m_rr, m_dv} = {c_sr, c_av, c_rr, c_dv};
        {m_dh, m_fd, m_bz} = {c_dh, c_fd, c_bz};
        m_ad = int'(c_ad);
        m_dx = int'(c_dx);
        m_dy = int'(c_dy);
      end
      3: begin
        {m_sr, m_av, m_rr, m_dv} = {d_sr, d_av, d_rr, d_dv};
        {m_dh, m_fd, m_bz} = {d_dh, d_fd, d_bz};
        m_ad = int'(d_ad);
        m_dx = int'(d_dx);
        m_dy = int'(d_dy);
      end
      default: ;
    endcase
  end

  int n_chk = 0;
  int n_fail = 0;

  int got_addr[$], got_x[$], got_y[$], got_hit[$];
  int exp_addr[$], exp_x[$], exp_y[$];
  int done_cnt;

  task automatic chk(input string name,
                     input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d",
               name, got, exp);
    end
  endtask

  task automatic build(input int iw, input int ih,
                       input int ww, input int wh,
                       input int st);
    exp_addr.delete();
    exp_x.delete();
    exp_y.delete();
    for (int y = 0; y + wh <= ih; y += st)
      for (int x = 0; x + ww <= iw; x += st) begin
        exp_x.push_back(x);
        exp_y.push_back(y);
        for (int py = 0; py < wh; py++)
          for (int px = 0; px < ww; px++)
            exp_addr.push_back((y + py) * iw + x + px);
      end
  endtask

  task automatic run(input bit stall, input bit inject,
                     input int stop_rec, input int stop_addr,
                     input bit hold, output int stall_err);
    bit fin, pa, pd;
    int pa_v, pd_v, res_cnt;
    got_addr.delete();
    got_x.delete();
    got_y.delete();
    got_hit.delete();
    done_cnt = 0;
    res_cnt = 0;
    stall_err = 0;
    fin = 0;
    pa = 0;
    pd = 0;
    pa_v = 0;
    pd_v = 0;
    start_valid = 1;
    @(negedge clk);
    for (int c = 0; c < 20000; c++) begin
      if (!hold && m_bz) start_valid = 0;
      if (pa && !(m_av && m_ad == pa_v)) stall_err++;
      if (pd && !(m_dv &&
          (m_dx * 4096 + m_dy * 2 + int'(m_dh)) == pd_v))
        stall_err++;
      addr_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      det_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      res_valid = 0;
      res_hit = 0;
      if (m_rr && (!stall || $urandom_range(0, 1) == 0)) begin
        res_valid = 1;
        res_hit = (res_cnt % 2 == 0);
        res_cnt++;
      end else if (inject && m_av &&
                   $urandom_range(0, 7) == 0) begin
        res_valid = 1;
        res_hit = 1;
      end
      pa = m_av && !addr_ready;
      pa_v = m_ad;
      pd = m_dv && !det_ready;
      pd_v = m_dx * 4096 + m_dy * 2 + int'(m_dh);
      if (m_fd) done_cnt++;
      if (m_av && addr_ready) begin
        got_addr.push_back(m_ad);
        if (stop_addr > 0 && got_addr.size() == stop_addr)
          fin = 1;
      end
      if (m_dv && det_ready) begin
        got_x.push_back(m_dx);
        got_y.push_back(m_dy);
        got_hit.push_back(int'(m_dh));
        if (stop_rec > 0 && got_x.size() == stop_rec)
          fin = 1;
      end
      if (m_fd) fin = 1;
      @(negedge clk);
      res_valid = 0;
      if (fin) break;
    end
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: no end of run within budget");
    end
  endtask

  task automatic pulse_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    int sel;
    int iw, ih, ww, wh, st;
    bit stall;
    bit inject;
    int stop_rec;
    int n_addr;
    int n_rec;
    int w0_last;
    int last_addr;
    int done;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int se, mis, hm, k;
    tbl[0] = '{0, 4, 4, 2, 2, 2, 0, 0, 0, 16, 4, 5, 15, 1};
    tbl[1] = '{0, 4, 4, 2, 2, 2, 1, 1, 0, 16, 4, 5, 15, 1};
    tbl[2] = '{2, 3, 3, 3, 3, 1, 0, 0, 0, 9, 1, 8, 8, 1};
    tbl[3] = '{3, 45, 45, 24, 24, 8, 0, 0, 0,
               5184, 9, 1058, 1794, 1};
    tbl[4] = '{3, 45, 45, 24, 24, 8, 1, 0, 0,
               5184, 9, 1058, 1794, 1};
    tbl[5] = '{1, 45, 45, 24, 24, 1, 0, 0, 2,
               1152, 2, 1058, 1059, 0};

    rst = 1;
    sel = 0;
    start_valid = 0;
    addr_ready = 0;
    res_valid = 0;
    res_hit = 0;
    det_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_start_ready", int'(m_sr), 1);
    chk("rst_busy", int'(m_bz), 0);
    chk("rst_addr_valid", int'(m_av), 0);
    chk("rst_det_valid", int'(m_dv), 0);
    chk("rst_frame_done", int'(m_fd), 0);
    rst = 0;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      sel = tbl[t].sel;
      build(tbl[t].iw, tbl[t].ih, tbl[t].ww,
            tbl[t].wh, tbl[t].st);
      run(tbl[t].stall, tbl[t].inject,
          tbl[t].stop_rec, 0, 0, se);
      mis = 0;
      foreach (got_addr[i])
        if (i >= exp_addr.size() || got_addr[i] != exp_addr[i])
          mis++;
      chk($sformatf("addr_seq[%0d]", t), mis, 0);
      mis = 0;
      hm = 0;
      foreach (got_x[i]) begin
        if (i >= exp_x.size() || got_x[i] != exp_x[i] ||
            got_y[i] != exp_y[i])
          mis++;
        if (got_hit[i] != ((i % 2 == 0) ? 1 : 0)) hm++;
      end
      chk($sformatf("rec_xy[%0d]", t), mis, 0);
      chk($sformatf("rec_hit[%0d]", t), hm, 0);
      chk($sformatf("n_addr[%0d]", t),
          got_addr.size(), tbl[t].n_addr);
      chk($sformatf("n_rec[%0d]", t),
          got_x.size(), tbl[t].n_rec);
      k = tbl[t].ww * tbl[t].wh - 1;
      chk($sformatf("w0_last[%0d]", t),
          (got_addr.size() > k) ? got_addr[k] : -1,
          tbl[t].w0_last);
      chk($sformatf("last_addr[%0d]", t),
          (got_addr.size() > 0) ? got_addr[$] : -1,
          tbl[t].last_addr);
      chk($sformatf("done_cnt[%0d]", t),
          done_cnt, tbl[t].done);
      chk($sformatf("stall_hold[%0d]", t), se, 0);
      if (tbl[t].done != 0) begin
        chk($sformatf("post_ready[%0d]", t), int'(m_sr), 1);
        chk($sformatf("post_busy[%0d]", t), int'(m_bz), 0);
        chk($sformatf("post_done[%0d]", t), int'(m_fd), 0);
      end
      pulse_reset();
    end

    sel = 0;
    build(4, 4, 2, 2, 2);
    run(0, 0, 0, 5, 0, se);
    chk("mid_n_addr", got_addr.size(), 5);
    chk("mid_addr4", got_addr.size() == 5 ? got_addr[4] : -1, 2);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_addr_valid", int'(m_av), 0);
    chk("mid_rst_start_ready", int'(m_sr), 1);
    chk("mid_rst_busy", int'(m_bz), 0);
    chk("mid_rst_det_valid", int'(m_dv), 0);
    rst = 0;
    @(negedge clk);
    run(0, 0, 0, 0, 0, se);
    chk("restart_first",
        got_addr.size() > 0 ? got_addr[0] : -1, 0);
    chk("restart_n_addr", got_addr.size(), 16);
    chk("restart_n_rec", got_x.size(), 4);

    run(0, 0, 0, 0, 1, se);
    chk("b2b_done", done_cnt, 1);
    chk("b2b_idle_ready", int'(m_sr), 1);
    @(negedge clk);
    chk("b2b_addr_valid", int'(m_av), 1);
    chk("b2b_addr0", m_ad, 0);
    start_valid = 0;
    pulse_reset();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
